// File: rtl/aibcr3_sync_deb.sv
// Multi-channel synchroniser with per-channel debounce and edge pulses.
// The sync flops of all channels also form one scan shift chain (si -> so).

module aibcr3_sync_deb_lane #(
  parameter int STAGES = 3,
  parameter int DEB_W  = 4
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             d,
  input  logic             se_n,
  input  logic             scan_in,
  input  logic             deb_en,
  input  logic [DEB_W-1:0] deb_thr,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic             scan_out
);
  logic [STAGES-1:0] s;
  logic [DEB_W-1:0]  cnt;
  logic              y, diff, upd;

  assign y        = s[STAGES-1];
  assign diff     = y ^ q;
  // cnt counts edges already seen with y!=q; >= lets a lowered threshold fire at once
  assign upd      = diff & (~deb_en | (cnt >= deb_thr));
  assign scan_out = s[STAGES-1];

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      s    <= '0;
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (!se_n) begin
      s    <= {s[STAGES-2:0], scan_in};
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s    <= {s[STAGES-2:0], d};
      rise <= upd & y;
      fall <= upd & ~y;
      if (upd) begin
        q   <= y;
        cnt <= '0;
      end else if (diff) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module aibcr3_sync_deb #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 3,
  parameter int DEB_W  = 4
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [WIDTH-1:0] D,
  input  logic             se_n,
  input  logic             si,
  input  logic             deb_en,
  input  logic [DEB_W-1:0] deb_thr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             so
);
  // chain[i] feeds channel i's first flop in scan mode; chain[WIDTH] is the tail
  logic [WIDTH:0] chain;

  assign chain[0] = si;
  assign so       = chain[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    aibcr3_sync_deb_lane #(.STAGES(STAGES), .DEB_W(DEB_W)) u_lane (
      .CP       (CP),
      .CD       (CD),
      .d        (D[i]),
      .se_n     (se_n),
      .scan_in  (chain[i]),
      .deb_en   (deb_en),
      .deb_thr  (deb_thr),
      .q        (Q[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .scan_out (chain[i+1])
    );
  end
endmodule

// File: doc/aibcr3_sync_deb.md
AIBCR3_SYNC_DEB -- requirements
Module: aibcr3_sync_deb

Interface
REQ-001 Parameter WIDTH, default 4, number of independent synchronised channels (legal 1..32).
REQ-002 Parameter STAGES, default 3, synchroniser flop depth per channel (legal 2..4).
REQ-003 Parameter DEB_W, default 4, debounce counter and threshold width (legal 1..8).
REQ-004 CP  input  1  rising-edge clock for all state.
REQ-005 CD  input  1  asynchronous, active-high reset/clear.
REQ-006 D  input  WIDTH  asynchronous data to be synchronised.
REQ-007 se_n  input  1  scan enable, active low (0 = scan shift).
REQ-008 si  input  1  scan chain serial input.
REQ-009 deb_en  input  1  debounce enable (quasi-static, CP domain).
REQ-010 deb_thr  input  DEB_W  debounce threshold T (quasi-static, CP domain).
REQ-011 Q  output  WIDTH  registered, synchronised, optionally debounced data.
REQ-012 rise  output  WIDTH  one-cycle pulse per channel when Q goes 0->1.
REQ-013 fall  output  WIDTH  one-cycle pulse per channel when Q goes 1->0.
REQ-014 so  output  1  scan chain serial output.

Function
REQ-015 Per channel i, flop s[i][0] SHALL load D[i] and flop s[i][k] SHALL load s[i][k-1] on every CP rising edge while se_n=1; y[i] = s[i][STAGES-1].
REQ-016 When se_n=0, sync flops SHALL form one shift chain: si -> s[0][0] -> ... -> s[0][STAGES-1] -> s[1][0] -> ... -> s[WIDTH-1][STAGES-1]; so SHALL equal s[WIDTH-1][STAGES-1] at all times.
REQ-017 When se_n=0, Q and debounce counters SHALL hold, and rise/fall SHALL register 0.
REQ-018 Per channel, DEB_W-bit counter cnt[i] SHALL update each edge (se_n=1): y!=Q and (deb_en=0 or cnt>=deb_thr) -> Q<=y, cnt<=0; else y!=Q -> cnt<=cnt+1; else cnt<=0.
REQ-019 cnt SHALL never exceed deb_thr+1 wrap-free; comparison is >= so lowering deb_thr mid-count causes update on the next edge where y!=Q.
REQ-020 deb_thr=0 or deb_en=0: D-to-Q latency SHALL be exactly STAGES+1 rising edges (D sampled at edge n, Q updates at edge n+STAGES).
REQ-021 deb_en=1, deb_thr=T: Q SHALL update at edge n+STAGES+T provided y stays different from Q for those T+1 consecutive edges; any edge with y==Q SHALL clear cnt.
REQ-022 A D pulse of w cycles SHALL be suppressed at Q when w<=T and SHALL pass when w>T (deb_en=1).
REQ-023 rise[i] SHALL be 1 for exactly the cycle following the edge where Q[i] loads 1 from 0; fall[i] likewise for 1->0; never both in one cycle for one channel.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on multiple channels SHALL be handled in parallel.

Reset
REQ-025 CD=1 SHALL asynchronously clear all sync flops, cnt, Q, rise, fall to 0; so=0 while CD=1.
REQ-026 CD deassertion SHALL take effect at the next CP edge; reset mid-debounce SHALL discard partial counts.
REQ-027 Reset SHALL override scan: CD=1 clears the chain regardless of se_n.

Verification
REQ-028 STAGES=3, deb_en=0: D[0] 0->1 sampled edge 10 -> Q[0]=1 after edge 13, rise[0]=1 for that one cycle only.
REQ-029 deb_en=1, deb_thr=4: D[1] high 4 cycles then low -> Q[1] stays 0, rise=0; D[1] high 5 cycles -> Q[1]=1 after edge n+7.
REQ-030 se_n=0, WIDTH=4, STAGES=3: shift pattern 1 then zeros via si -> so=1 exactly 12 edges later; Q/cnt unchanged, rise/fall=0 throughout.
REQ-031 CD pulsed while cnt[2]=3 of deb_thr=5 -> Q, cnt, rise, fall = 0 immediately; after release, full STAGES+5 latency required again.
REQ-032 All channels toggle 0->1 same cycle with deb_en=0 -> Q=all ones same edge, rise=all ones one cycle; then all 1->0 -> fall=all ones one cycle.
